// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one dual-carry adder among NREQ requesters (define ADDER_ARB_FASTCAP_EN to drop the ISSUE settle cycle)
module adder_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    input  logic [NREQ-1:0]       req_cin_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [NREQ-1:0]       resp_id_o,
    output logic [WIDTH-1:0]      resp_sum_o,
    output logic                  resp_cout_o,
    output logic [WIDTH-1:0]      add_a_o,
    output logic [WIDTH-1:0]      add_b_o,
    input  logic [WIDTH-1:0]      add_sum0_i,
    input  logic [WIDTH-1:0]      add_sum1_i,
    input  logic                  add_c0_i,
    input  logic                  add_c1_i
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;
`ifdef ADDER_ARB_FASTCAP_EN
    localparam state_e AFTER_GRANT = CAPTURE;
`else
    localparam state_e AFTER_GRANT = ISSUE;
`endif
    state_e            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d, gnt_idx;
    logic              gnt_any;
    logic [NREQ-1:0]   gnt_oh;
    logic [WIDTH-1:0]  add_a_q, add_a_d, add_b_q, add_b_d, resp_sum_q, resp_sum_d;
    logic              cin_q, cin_d, resp_cout_q, resp_cout_d;
    logic [NREQ-1:0]   id_q, id_d, resp_id_q, resp_id_d;
    function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] p, int k);
        int s = int'(p) + k;
        return PW'((s >= NREQ) ? s - NREQ : s);
    endfunction
    // first valid requester at or after the pointer; scanning downward lets the nearest one win
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[wrap_add(rr_ptr_q, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_add(rr_ptr_q, k);
            end
        end
    end
    assign gnt_oh       = NREQ'(1) << gnt_idx;
    assign req_ready_o  = (rst_n && state_q == IDLE && gnt_any) ? gnt_oh : '0;
    assign resp_valid_o = (state_q == RESP);
    assign resp_id_o    = resp_id_q;
    assign resp_sum_o   = resp_sum_q;
    assign resp_cout_o  = resp_cout_q;
    assign add_a_o      = add_a_q;
    assign add_b_o      = add_b_q;
    // transaction sequencing: grant and latch operands, let the adder settle, capture the chosen carry variant, hold the response
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        cin_d       = cin_q;
        id_d        = id_q;
        resp_id_d   = resp_id_q;
        resp_sum_d  = resp_sum_q;
        resp_cout_d = resp_cout_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    add_a_d  = req_a_i[int'(gnt_idx)*WIDTH +: WIDTH];
                    add_b_d  = req_b_i[int'(gnt_idx)*WIDTH +: WIDTH];
                    cin_d    = req_cin_i[gnt_idx];
                    id_d     = gnt_oh;
                    rr_ptr_d = wrap_add(gnt_idx, 1);
                    state_d  = AFTER_GRANT;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                resp_sum_d  = cin_q ? add_sum1_i : add_sum0_i;
                resp_cout_d = cin_q ? add_c1_i : add_c0_i;
                resp_id_d   = id_q;
                state_d     = RESP;
            end
            RESP: state_d = resp_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers; reset discards any in-flight transaction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            cin_q       <= 1'b0;
            id_q        <= '0;
            resp_id_q   <= '0;
            resp_sum_q  <= '0;
            resp_cout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            cin_q       <= cin_d;
            id_q        <= id_d;
            resp_id_q   <= resp_id_d;
            resp_sum_q  <= resp_sum_d;
            resp_cout_q <= resp_cout_d;
        end
    end
endmodule
